// File: rtl/i4003_driver_pkg.sv
// Shared types and constants for the i4003 shift-register chain driver.
package i4003_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        ENABLE
    } state_t;

    localparam int STAGE_BITS = 10;

endpackage

// File: rtl/i4003_driver_if.sv
// Host-side request/response bundle between CPU I/O port logic and the driver.
interface i4003_driver_if #(
    parameter int WIDTH = 10
);
    logic             load;
    logic [WIDTH-1:0] word;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] rdata;

    modport master (output load, output word, input busy, input done, input rdata);
    modport slave  (input load, input word, output busy, output done, output rdata);
endinterface

// File: rtl/i4003_driver.sv
// Serializes a parallel word MSB first into a cascaded i4003 chain, pulses the
// enable afterwards and collects the chain's previous contents from its serial output.
module i4003_driver
    import i4003_pkg::*;
#(
    parameter int CHAIN  = 1,
    parameter int DIV    = 2,
    parameter int EN_CYC = 3
) (
    input  logic           cp,
    input  logic           rst_n,
    i4003_driver_if.slave  host,
    output logic           sr_cp,
    output logic           sr_data,
    output logic           sr_e,
    input  logic           s_in
);

    localparam int WIDTH = STAGE_BITS * CHAIN;
    localparam int MAXC  = (DIV > EN_CYC) ? DIV : EN_CYC;
    localparam int PW    = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int BW    = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [PW-1:0]    phase_q, phase_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic [WIDTH-1:0] rshift_q, rshift_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             sr_cp_q, sr_cp_d;
    logic             sr_data_q, sr_data_d;
    logic             sr_e_q, sr_e_d;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_cnt_d = bit_cnt_q;
        buf_d     = buf_q;
        rshift_d  = rshift_q;
        rdata_d   = rdata_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                // A load coinciding with done belongs to the finished transfer's handshake.
                if (host.load && !done_q) begin
                    buf_d     = host.word;
                    bit_cnt_d = '0;
                    phase_d   = '0;
                    busy_d    = 1'b1;
                    state_d   = LOW;
                end
            end
            LOW: begin
                if (phase_q == PW'(DIV - 1)) begin
                    phase_d  = '0;
                    rshift_d = {rshift_q[WIDTH-2:0], s_in};
                    state_d  = HIGH;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            HIGH: begin
                if (phase_q == PW'(DIV - 1)) begin
                    phase_d   = '0;
                    buf_d     = {buf_q[WIDTH-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    state_d   = (bit_cnt_d == BW'(WIDTH)) ? ENABLE : LOW;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            ENABLE: begin
                if (phase_q == PW'(EN_CYC - 1)) begin
                    phase_d = '0;
                    rdata_d = rshift_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Pin values follow the upcoming state so every chain pin is a flop output.
        sr_cp_d   = (state_d == HIGH);
        sr_e_d    = (state_d == ENABLE);
        sr_data_d = ((state_d == LOW) || (state_d == HIGH)) ? buf_d[WIDTH-1] : 1'b0;
    end

    always_ff @(posedge cp or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            bit_cnt_q <= '0;
            buf_q     <= '0;
            rshift_q  <= '0;
            rdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sr_cp_q   <= 1'b0;
            sr_data_q <= 1'b0;
            sr_e_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_cnt_q <= bit_cnt_d;
            buf_q     <= buf_d;
            rshift_q  <= rshift_d;
            rdata_q   <= rdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sr_cp_q   <= sr_cp_d;
            sr_data_q <= sr_data_d;
            sr_e_q    <= sr_e_d;
        end
    end

    assign host.busy  = busy_q;
    assign host.done  = done_q;
    assign host.rdata = rdata_q;
    assign sr_cp      = sr_cp_q;
    assign sr_data    = sr_data_q;
    assign sr_e       = sr_e_q;

endmodule
